// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the load-use hazard control unit.
//   hz_state_e : FSM state encoding (StIdle = 0, StLuWait = 1)
//   hz_out_t   : bundle of the five pipeline-control outputs
//   HzOut*     : output constants for idle, load-use stall, cache freeze and branch flush
//   X0Addr     : architectural zero register, never a real dependency
package hazard_pkg;

  typedef enum logic {
    StIdle   = 1'b0,
    StLuWait = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic pc_write;
    logic stall;
    logic noop;
    logic mem_stall;
    logic flush;
  } hz_out_t;

  localparam hz_out_t HzOutIdle  = '{pc_write: 1'b1, stall: 1'b0, noop: 1'b0,
                                     mem_stall: 1'b0, flush: 1'b0};
  localparam hz_out_t HzOutStall = '{pc_write: 1'b0, stall: 1'b1, noop: 1'b1,
                                     mem_stall: 1'b0, flush: 1'b0};
  localparam hz_out_t HzOutBusy  = '{pc_write: 1'b0, stall: 1'b1, noop: 1'b0,
                                     mem_stall: 1'b1, flush: 1'b0};
  localparam hz_out_t HzOutFlush = '{pc_write: 1'b1, stall: 1'b0, noop: 1'b0,
                                     mem_stall: 1'b0, flush: 1'b1};

  localparam int unsigned X0Addr = 0;

endpackage

// File: rtl/hazard_match.sv
// hazard_match: NUM_SRC-way load-use comparator.
//   rs_addr_i  : packed ID source addresses, operand k at [k*ADDR_W +: ADDR_W]
//   rs_used_i  : per-operand read qualifier
//   mem_read_i : instruction in EX is a load
//   rd_addr_i  : destination of the instruction in EX
//   hit_o      : a used, non-x0 operand depends on the load in EX
module hazard_match
  import hazard_pkg::*;
#(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_SRC = 2
) (
  input  logic [NUM_SRC*ADDR_W-1:0] rs_addr_i,
  input  logic [NUM_SRC-1:0]        rs_used_i,
  input  logic                      mem_read_i,
  input  logic [ADDR_W-1:0]         rd_addr_i,
  output logic                      hit_o
);

  logic [NUM_SRC-1:0] w_slot_hit;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_slot
    assign w_slot_hit[k] = rs_used_i[k] && (rs_addr_i[k*ADDR_W +: ADDR_W] == rd_addr_i);
  end

  assign hit_o = mem_read_i && (rd_addr_i != ADDR_W'(X0Addr)) && (|w_slot_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / cache-busy / branch-flush hazard control for the in-order pipeline.
//   clk_i, rst_i  : clock and synchronous active-low reset
//   RSaddr_i      : ID source addresses (NUM_SRC x ADDR_W)
//   RSused_i      : per-operand read qualifier
//   MemRead_i     : EX instruction is a load
//   RDaddr_i      : EX destination
//   MemBusy_i     : data cache not ready, freeze everything
//   BranchTaken_i : branch resolved taken in ID
//   PCWrite_o, Stall_o, NoOp_o, MemStall_o, Flush_o : pipeline control (combinational)
//   StallCnt_o    : saturating count of load-use bubble cycles
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_SRC*ADDR_W-1:0] RSaddr_i,
  input  logic [NUM_SRC-1:0]        RSused_i,
  input  logic                      MemRead_i,
  input  logic [ADDR_W-1:0]         RDaddr_i,
  input  logic                      MemBusy_i,
  input  logic                      BranchTaken_i,
  output logic                      PCWrite_o,
  output logic                      Stall_o,
  output logic                      NoOp_o,
  output logic                      MemStall_o,
  output logic                      Flush_o,
  output logic [CNT_W-1:0]          StallCnt_o
);

  localparam int unsigned RemW = $clog2(LOAD_STALL + 1);

  hz_state_e        r_state;
  logic [RemW-1:0]  r_rem;
  logic [CNT_W-1:0] r_cnt;

  logic    w_hit;
  logic    w_lu;
  hz_out_t w_out;

  hazard_match #(
    .ADDR_W (ADDR_W),
    .NUM_SRC(NUM_SRC)
  ) u_match (
    .rs_addr_i (RSaddr_i),
    .rs_used_i (RSused_i),
    .mem_read_i(MemRead_i),
    .rd_addr_i (RDaddr_i),
    .hit_o     (w_hit)
  );

  // In LU_WAIT the bubbles already in flight own the stall regardless of the ID inputs.
  assign w_lu = (r_state == StLuWait) || w_hit;

  always_comb begin
    w_out = HzOutIdle;
    if (!rst_i) begin
      w_out = HzOutIdle;
    end else if (MemBusy_i) begin
      w_out = HzOutBusy;
    end else if (w_lu) begin
      w_out = HzOutStall;
    end else if (BranchTaken_i) begin
      w_out = HzOutFlush;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= StIdle;
      r_rem   <= '0;
      r_cnt   <= '0;
    end else if (!MemBusy_i) begin
      // A busy cycle holds everything; a pending hit is simply re-seen afterwards.
      if (w_lu && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == StLuWait) begin
        r_rem <= r_rem - 1'b1;
        if (r_rem == RemW'(1)) begin
          r_state <= StIdle;
        end
      end else if (w_hit && (LOAD_STALL > 1)) begin
        r_state <= StLuWait;
        r_rem   <= RemW'(LOAD_STALL - 1);
      end
    end
  end

  assign PCWrite_o  = w_out.pc_write;
  assign Stall_o    = w_out.stall;
  assign NoOp_o     = w_out.noop;
  assign MemStall_o = w_out.mem_stall;
  assign Flush_o    = w_out.flush;
  assign StallCnt_o = r_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  // {PCWrite, Stall, NoOp, MemStall, Flush}
  localparam logic [4:0] O_IDLE  = 5'b10000;
  localparam logic [4:0] O_STALL = 5'b01100;
  localparam logic [4:0] O_BUSY  = 5'b01010;
  localparam logic [4:0] O_FLUSH = 5'b10001;

  logic        clk = 1'b0;
  logic        t_rst, t_mr, t_busy, t_br;
  logic [4:0]  t_rd;
  logic [14:0] t_rs;
  logic [2:0]  t_used;

  logic [4:0] a_o, b_o, c_o;
  logic [3:0] a_cnt;
  logic [7:0] b_cnt;
  logic [5:0] c_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // A: 2 sources, 1 bubble, 4-bit counter
  hazard_ctrl #(.ADDR_W(5), .NUM_SRC(2), .LOAD_STALL(1), .CNT_W(4)) dut_a (
    .clk_i(clk), .rst_i(t_rst), .RSaddr_i(t_rs[9:0]), .RSused_i(t_used[1:0]),
    .MemRead_i(t_mr), .RDaddr_i(t_rd), .MemBusy_i(t_busy), .BranchTaken_i(t_br),
    .PCWrite_o(a_o[4]), .Stall_o(a_o[3]), .NoOp_o(a_o[2]), .MemStall_o(a_o[1]),
    .Flush_o(a_o[0]), .StallCnt_o(a_cnt)
  );

  // B: 2 sources, 3 bubbles, 8-bit counter
  hazard_ctrl #(.ADDR_W(5), .NUM_SRC(2), .LOAD_STALL(3), .CNT_W(8)) dut_b (
    .clk_i(clk), .rst_i(t_rst), .RSaddr_i(t_rs[9:0]), .RSused_i(t_used[1:0]),
    .MemRead_i(t_mr), .RDaddr_i(t_rd), .MemBusy_i(t_busy), .BranchTaken_i(t_br),
    .PCWrite_o(b_o[4]), .Stall_o(b_o[3]), .NoOp_o(b_o[2]), .MemStall_o(b_o[1]),
    .Flush_o(b_o[0]), .StallCnt_o(b_cnt)
  );

  // C: 3 sources, 2 bubbles, 6-bit counter
  hazard_ctrl #(.ADDR_W(5), .NUM_SRC(3), .LOAD_STALL(2), .CNT_W(6)) dut_c (
    .clk_i(clk), .rst_i(t_rst), .RSaddr_i(t_rs), .RSused_i(t_used),
    .MemRead_i(t_mr), .RDaddr_i(t_rd), .MemBusy_i(t_busy), .BranchTaken_i(t_br),
    .PCWrite_o(c_o[4]), .Stall_o(c_o[3]), .NoOp_o(c_o[2]), .MemStall_o(c_o[1]),
    .Flush_o(c_o[0]), .StallCnt_o(c_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs mid-period; outputs settle before the next rising edge.
  task automatic drive(input logic rst, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] used,
                       input logic busy, input logic br);
    @(negedge clk);
    t_rst = rst; t_mr = mr; t_rd = rd; t_rs = {5'd0, rs2, rs1};
    t_used = used; t_busy = busy; t_br = br;
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] used;
    logic       busy;
    logic       br;
    logic [4:0] eo;
    logic [3:0] ec;
  } vec_t;

  vec_t tbl[11];

  int         ls   [3] = '{1, 3, 2};
  int         cmax [3] = '{15, 255, 63};
  int         nsrc [3] = '{2, 2, 3};
  int         m_pend [3];
  int         m_cnt  [3];
  logic       h;
  logic [4:0] eo;
  logic [4:0] dout;
  logic [31:0] dcnt;

  initial begin
    t_rst = 1'b0; t_mr = 1'b0; t_rd = '0; t_rs = '0; t_used = '0; t_busy = 1'b0; t_br = 1'b0;

    // ---------------- table-driven single-cycle vectors on dut_a ----------------
    //          rst  mr   rd  rs1 rs2 used busy br  out      cnt(before edge)
    tbl[0]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, O_IDLE,  4'd0};
    tbl[1]  = '{1'b1, 1'b1, 5'd5, 5'd5, 5'd1, 3'b001, 1'b0, 1'b0, O_STALL, 4'd0};
    tbl[2]  = '{1'b1, 1'b0, 5'd5, 5'd5, 5'd1, 3'b001, 1'b0, 1'b0, O_IDLE,  4'd1};
    tbl[3]  = '{1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 3'b011, 1'b0, 1'b0, O_IDLE,  4'd1};
    tbl[4]  = '{1'b1, 1'b1, 5'd7, 5'd2, 5'd7, 3'b001, 1'b0, 1'b0, O_IDLE,  4'd1};
    tbl[5]  = '{1'b1, 1'b0, 5'd7, 5'd2, 5'd7, 3'b011, 1'b0, 1'b1, O_FLUSH, 4'd1};
    tbl[6]  = '{1'b1, 1'b1, 5'd3, 5'd9, 5'd3, 3'b010, 1'b0, 1'b1, O_STALL, 4'd1};
    tbl[7]  = '{1'b1, 1'b1, 5'd3, 5'd9, 5'd3, 3'b010, 1'b1, 1'b0, O_BUSY,  4'd2};
    tbl[8]  = '{1'b1, 1'b1, 5'd3, 5'd9, 5'd3, 3'b010, 1'b0, 1'b0, O_STALL, 4'd2};
    tbl[9]  = '{1'b0, 1'b1, 5'd3, 5'd9, 5'd3, 3'b010, 1'b0, 1'b1, O_IDLE,  4'd3};
    tbl[10] = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, O_IDLE,  4'd0};

    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].rst, tbl[i].mr, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].used,
            tbl[i].busy, tbl[i].br);
      chk($sformatf("tbl%0d_out", i), 32'(a_o), 32'(tbl[i].eo));
      chk($sformatf("tbl%0d_cnt", i), 32'(a_cnt), 32'(tbl[i].ec));
    end

    // ---------------- dut_a: counter saturation ----------------
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 5'd4, 5'd4, 5'd4, 3'b011, 1'b0, 1'b0);
    chk("sat_out", 32'(a_o), 32'(O_STALL));
    chk("sat_cnt", 32'(a_cnt), 32'd15);

    // ---------------- dut_b: three bubbles, MemRead drops, branch ignored ----------------
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 3'b001, 1'b0, 1'b0);
    chk("ls3_t0", 32'(b_o), 32'(O_STALL));
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b1);
    chk("ls3_t1", 32'(b_o), 32'(O_STALL));
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
    chk("ls3_t2", 32'(b_o), 32'(O_STALL));
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
    chk("ls3_t3", 32'(b_o), 32'(O_IDLE));
    chk("ls3_cnt", 32'(b_cnt), 32'd3);

    // ---------------- dut_b: busy interleaved with bubbles ----------------
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 5'd6, 5'd1, 5'd6, 3'b010, 1'b0, 1'b0);
    chk("busy_t0", 32'(b_o), 32'(O_STALL));
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0);
    chk("busy_t1", 32'(b_o), 32'(O_BUSY));
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0);
    chk("busy_t2", 32'(b_o), 32'(O_BUSY));
    chk("busy_cnt_hold", 32'(b_cnt), 32'd1);
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
    chk("busy_t3", 32'(b_o), 32'(O_STALL));
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
    chk("busy_t4", 32'(b_o), 32'(O_STALL));
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
    chk("busy_t5", 32'(b_o), 32'(O_IDLE));
    chk("busy_cnt", 32'(b_cnt), 32'd3);

    // ---------------- dut_b: reset in mid-LU_WAIT ----------------
    drive(1'b1, 1'b1, 5'd2, 5'd2, 5'd0, 3'b001, 1'b0, 1'b0);
    chk("rst_t0", 32'(b_o), 32'(O_STALL));
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
    chk("rst_t1", 32'(b_o), 32'(O_IDLE));
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
    chk("rst_t2", 32'(b_o), 32'(O_IDLE));
    chk("rst_cnt", 32'(b_cnt), 32'd0);

    // ---------------- random stimulus vs. bubble-budget model, all three DUTs ----------------
    for (int d = 0; d < 3; d++) begin
      m_pend[d] = 0;
      m_cnt[d]  = 0;
    end
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      t_rst  = (i == 0) ? 1'b0 : ($urandom_range(0, 60) != 0);
      t_mr   = 1'($urandom_range(0, 1));
      t_rd   = 5'($urandom_range(0, 3));
      t_rs   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      t_used = 3'($urandom_range(0, 7));
      t_busy = ($urandom_range(0, 5) == 0);
      t_br   = ($urandom_range(0, 4) == 0);
      #1;
      for (int d = 0; d < 3; d++) begin
        h = 1'b0;
        for (int k = 0; k < nsrc[d]; k++) begin
          if (t_used[k] && (t_rs[k*5 +: 5] == t_rd)) h = 1'b1;
        end
        h = h && t_mr && (t_rd != 5'd0);
        case (d)
          0:       begin dout = a_o; dcnt = 32'(a_cnt); end
          1:       begin dout = b_o; dcnt = 32'(b_cnt); end
          default: begin dout = c_o; dcnt = 32'(c_cnt); end
        endcase
        if (!t_rst)                   eo = O_IDLE;
        else if (t_busy)              eo = O_BUSY;
        else if (m_pend[d] > 0 || h)  eo = O_STALL;
        else if (t_br)                eo = O_FLUSH;
        else                          eo = O_IDLE;
        chk($sformatf("rnd%0d_dut%0d_out", i, d), 32'(dout), 32'(eo));
        chk($sformatf("rnd%0d_dut%0d_cnt", i, d), dcnt, 32'(m_cnt[d]));
        // Model: count of bubbles still owed after this cycle.
        if (!t_rst) begin
          m_pend[d] = 0;
          m_cnt[d]  = 0;
        end else if (!t_busy && (m_pend[d] > 0 || h)) begin
          if (m_pend[d] > 0) m_pend[d] = m_pend[d] - 1;
          else               m_pend[d] = ls[d] - 1;
          if (m_cnt[d] < cmax[d]) m_cnt[d] = m_cnt[d] + 1;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard-control unit for the in-order RISC-V pipeline. It generalises load-use detection in four ways:
- a configurable source-operand count;
- per-operand "used" qualification and x0 exclusion;
- a configurable multi-cycle load-use stall driven by an internal counter and FSM;
- a data-cache busy freeze and a branch-flush output that yields to stalls.

It sits between the ID stage (source addresses) and the ID/EX register (load destination), and drives PC write-enable, IF/ID hold, the ID/EX bubble and the pipeline freeze. A saturating counter reports load-use stall cycles for performance measurement.

## Interface
Parameters:
- ADDR_W, 5, register address width
- NUM_SRC, 2, source operands checked per instruction (1..3)
- LOAD_STALL, 1, bubbles needed between a load in EX and a dependent consumer (1..7)
- CNT_W, 32, width of the stall performance counter

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous reset, active-low
- RSaddr_i  in  NUM_SRC*ADDR_W  ID source addresses; operand k occupies bits [k*ADDR_W +: ADDR_W]
- RSused_i  in  NUM_SRC  bit k=1 when operand k is actually read by the ID instruction
- MemRead_i  in  1  instruction in EX is a load
- RDaddr_i  in  ADDR_W  destination of the instruction in EX
- MemBusy_i  in  1  data cache not ready; whole pipeline must freeze
- BranchTaken_i  in  1  branch resolved taken in ID
- PCWrite_o  out  1  PC update enable
- Stall_o  out  1  hold IF/ID
- NoOp_o  out  1  insert bubble into ID/EX
- MemStall_o  out  1  freeze ID/EX, EX/MEM, MEM/WB
- Flush_o  out  1  flush IF/ID
- StallCnt_o  out  CNT_W  saturating count of load-use bubble cycles

## Operation
- Hazard condition `hit`: MemRead_i=1, RDaddr_i≠0, and some k has RSused_i[k]=1 with RSaddr_i slot k = RDaddr_i.
- FSM states are IDLE and LU_WAIT. A down-counter `rem` (width clog2(LOAD_STALL+1)) tracks the remaining bubbles.
- Priority order: reset, then MemBusy_i, then load-use (hit or LU_WAIT), then branch, then idle.
- MemBusy_i=1:
  - Outputs: PCWrite_o=0, Stall_o=1, NoOp_o=0, MemStall_o=1, Flush_o=0.
  - FSM state, `rem` and StallCnt_o hold.
  - A `hit` seen during busy is not acted on; it is re-evaluated once busy drops.
- IDLE with hit:
  - Outputs: PCWrite_o=0, Stall_o=1, NoOp_o=1, Flush_o=0.
  - If LOAD_STALL>1, go to LU_WAIT with rem=LOAD_STALL-1; otherwise stay in IDLE.
  - StallCnt_o increments.
- LU_WAIT:
  - Outputs are the same as IDLE with hit.
  - Each cycle rem decrements and StallCnt_o increments.
  - When rem=1 the FSM returns to IDLE on the next edge.
  - Inputs are ignored for the transition, because ID/EX now holds bubbles.
- BranchTaken_i=1 with no stall: Flush_o=1, PCWrite_o=1, all other outputs 0.
- BranchTaken_i=1 during a stall: Flush_o=0. The branch re-resolves after the stall.
- Idle: PCWrite_o=1, all other outputs 0.
- StallCnt_o saturates at all-ones; it never wraps.
- With NUM_SRC=2 and LOAD_STALL=1, the outputs match the classic single-bubble unit, except that x0 and unused operands are now excluded.

## Timing
- All outputs are combinational (Mealy) from the current state and inputs. The detect cycle therefore stalls with zero latency.
- Total load-use bubbles per hit = LOAD_STALL cycles, excluding any MemBusy_i cycles interleaved with them.
- Reset:
  - While rst_i=0 at an edge, the next state is IDLE, rem=0 and StallCnt_o=0.
  - While rst_i=0, outputs are forced to idle values: PCWrite_o=1, all others 0.
  - Reset asserted in mid-LU_WAIT aborts the stall immediately.
- A MemBusy_i rise in mid-LU_WAIT pauses rem. The remaining bubbles resume on the first non-busy cycle.

## Structure
- Shared package hazard_pkg holds:
  - the FSM state encoding (IDLE=1'b0, LU_WAIT=1'b1);
  - the idle output constants;
  - the X0 address constant.
- One sub-module, hazard_match: combinational NUM_SRC-way comparator producing `hit`, generated per operand and reduced with OR. The FSM, counter and output mux stay in hazard_ctrl.

## Test plan
- NUM_SRC=2, LOAD_STALL=1: MemRead=1, RD=5, RS1=5 used → one cycle of PCWrite=0/Stall=1/NoOp=1; StallCnt goes 0→1; next cycle (MemRead=0) returns to idle.
- RD=0, RS1=0 used, MemRead=1 → no stall. RD=7, RS2=7 with RSused[1]=0 → no stall.
- LOAD_STALL=3: hit at cycle t → stall outputs on t, t+1 and t+2 even though MemRead_i drops at t+1; idle at t+3; StallCnt=3.
- LOAD_STALL=3: hit at t, MemBusy_i=1 at t+1..t+2 → MemStall_o=1/NoOp_o=0 on those cycles; load-use bubbles on t, t+3 and t+4; StallCnt=3.
- BranchTaken_i=1 with no hit → Flush_o=1, PCWrite_o=1. BranchTaken_i=1 together with a hit → Flush_o=0, stall outputs asserted.
- CNT_W=4: 20 consecutive hits with LOAD_STALL=1 → StallCnt_o saturates at 15. rst_i=0 asserted in mid-LU_WAIT → next cycle idle outputs and StallCnt_o=0.
